// File: rtl/scan_mux.sv
// scan_mux: N-channel, W-bit registered multiplexer with manual select and
// autonomous round-robin scan (programmable dwell per channel).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in         packed channels, channel k = in[k*DATA_W +: DATA_W]
//   en         block enable
//   mode       0 = manual, 1 = scan
//   sel        manual channel select
//   dwell      scan: cycles per channel minus 1
//   out        registered selected data
//   out_ch     channel index that out came from
//   out_valid  out/out_ch valid this cycle
//   wrap       one-cycle pulse on the first channel-0 output after channel N_CH-1
module scan_mux #(
  parameter  int unsigned N_CH    = 16,
  parameter  int unsigned DATA_W  = 4,
  parameter  int unsigned DWELL_W = 8,
  localparam int unsigned SEL_W   = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   in,
  input  logic                     en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [DATA_W-1:0]        out,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  output logic                     wrap
);

  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t               state;
  state_t               nxt_c;
  logic                 sel_ok_c;
  logic [SEL_W-1:0]     ch;
  logic [DWELL_W-1:0]   dcnt;

  // Channel extraction by explicit compare so out-of-range indices yield 0.
  function automatic logic [DATA_W-1:0] pick(input logic [N_CH*DATA_W-1:0] bus,
                                             input logic [SEL_W-1:0]       idx);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) res = bus[k*DATA_W +: DATA_W];
    end
    return res;
  endfunction

  // Mode decode; the register stage below acts on the state being entered.
  always_comb begin
    nxt_c    = IDLE;
    sel_ok_c = ({1'b0, sel} < N_CH_EXT);
    if (en) nxt_c = mode ? SCAN : MANUAL;
  end

  // State, scan position and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch        <= '0;
      dcnt      <= '0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state <= nxt_c;
      wrap  <= 1'b0;
      unique case (nxt_c)
        IDLE: begin
          out_valid <= 1'b0;
          ch        <= '0;
          dcnt      <= '0;
        end
        MANUAL: begin
          out       <= sel_ok_c ? pick(in, sel) : '0;
          out_ch    <= sel;
          out_valid <= sel_ok_c;
          ch        <= '0;
          dcnt      <= '0;
        end
        SCAN: begin
          out       <= pick(in, ch);
          out_ch    <= ch;
          out_valid <= 1'b1;
          // ch=0 with dcnt=0 while already scanning only follows a wrap;
          // on entry the previous state is not SCAN.
          wrap      <= (state == SCAN) && (ch == '0) && (dcnt == '0);
          if (dcnt >= dwell) begin
            dcnt <= '0;
            ch   <= (ch == LAST_CH) ? '0 : ch + SEL_W'(1);
          end else begin
            dcnt <= dcnt + DWELL_W'(1);
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

  logic        clk;
  logic        rst_n;

  logic [63:0] in_a;
  logic        en_a, mode_a;
  logic [3:0]  sel_a;
  logic [7:0]  dwell_a;
  logic [3:0]  out_a;
  logic [3:0]  out_ch_a;
  logic        out_valid_a, wrap_a;

  logic [79:0] in_b;
  logic        en_b, mode_b;
  logic [3:0]  sel_b;
  logic [7:0]  dwell_b;
  logic [7:0]  out_b;
  logic [3:0]  out_ch_b;
  logic        out_valid_b, wrap_b;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          dut;
    logic [7:0]  o;
    logic [3:0]  c;
    logic        v;
    logic        w;
    string       nm;
  } exp_t;

  exp_t q[$];

  scan_mux u_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .en(en_a), .mode(mode_a),
    .sel(sel_a), .dwell(dwell_a), .out(out_a), .out_ch(out_ch_a),
    .out_valid(out_valid_a), .wrap(wrap_a)
  );

  scan_mux #(.N_CH(10), .DATA_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .en(en_b), .mode(mode_b),
    .sel(sel_b), .dwell(dwell_b), .out(out_b), .out_ch(out_ch_b),
    .out_valid(out_valid_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void compare(input exp_t e);
    logic [7:0] go;
    logic [3:0] gc;
    logic       gv, gw;
    if (e.dut == 0) begin
      go = {4'h0, out_a}; gc = out_ch_a; gv = out_valid_a; gw = wrap_a;
    end else begin
      go = out_b; gc = out_ch_b; gv = out_valid_b; gw = wrap_b;
    end
    n_vec++;
    if ({go, gc, gv, gw} !== {e.o, e.c, e.v, e.w}) begin
      n_bad++;
      $display("FAIL %s: got out=%h ch=%0d v=%b w=%b, want out=%h ch=%0d v=%b w=%b",
               e.nm, go, gc, gv, gw, e.o, e.c, e.v, e.w);
    end
  endfunction

  // Monitor: one registered output per edge, checked against the queue head.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) compare(q.pop_front());
  end

  // Push the expectation for the coming edge, then advance to the next negedge.
  task automatic cyc(input int dut, input logic [7:0] o, input logic [3:0] c,
                     input logic v, input logic w, input string nm);
    exp_t e;
    e.dut = dut; e.o = o; e.c = c; e.v = v; e.w = w; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_now(input int dut, input logic [7:0] o, input logic [3:0] c,
                           input logic v, input logic w, input string nm);
    exp_t e;
    e.dut = dut; e.o = o; e.c = c; e.v = v; e.w = w; e.nm = nm;
    compare(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] c;
    logic [7:0] o;
    rst_n = 1'b0;
    in_a = 64'hFEDC_BA98_7654_3210;
    en_a = 0; mode_a = 0; sel_a = 0; dwell_a = 0;
    for (int k = 0; k < 10; k++) in_b[k*8 +: 8] = 8'(16 + k);
    en_b = 0; mode_b = 0; sel_b = 0; dwell_b = 0;

    #2;
    check_now(0, 8'h00, 4'd0, 1'b0, 1'b0, "reset_a");
    check_now(1, 8'h00, 4'd0, 1'b0, 1'b0, "reset_b");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 8'h00, 4'd0, 1'b0, 1'b0, "idle_after_reset");

    // Manual select, 1-cycle latency
    en_a = 1; mode_a = 0; sel_a = 4'h6;
    cyc(0, 8'h06, 4'd6, 1'b1, 1'b0, "manual_sel6");
    sel_a = 4'hC;
    cyc(0, 8'h0C, 4'd12, 1'b1, 1'b0, "manual_selC");

    // Scan dwell=2: 3 cycles per channel, wrap every 48 cycles
    mode_a = 1; dwell_a = 8'd2;
    for (int i = 0; i < 100; i++) begin
      c = 4'((i / 3) % 16);
      cyc(0, {4'h0, c}, c, 1'b1, (i > 0) && (i % 48 == 0), "scan_dwell2");
    end

    // Disable: valid drops, data/tag hold
    en_a = 0;
    cyc(0, 8'h01, 4'd1, 1'b0, 1'b0, "idle_hold");

    // Scan dwell=0 with live data change on channel 3
    en_a = 1; mode_a = 1; dwell_a = 8'd0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) in_a[15:12] = 4'hA;
      c = 4'(i % 16);
      o = (c == 4'd3) ? 8'h0A : {4'h0, c};
      cyc(0, o, c, 1'b1, i == 16, "scan_dwell0_live");
    end
    in_a = 64'hFEDC_BA98_7654_3210;
    en_a = 0;
    cyc(0, 8'h0A, 4'd3, 1'b0, 1'b0, "idle_hold2");

    // Leave scan mid-dwell at ch 7, then re-enter
    en_a = 1; mode_a = 1; dwell_a = 8'd3;
    for (int i = 0; i < 30; i++) begin
      c = 4'(i / 4);
      cyc(0, {4'h0, c}, c, 1'b1, 1'b0, "scan_dwell3");
    end
    mode_a = 0; sel_a = 4'd2;
    cyc(0, 8'h02, 4'd2, 1'b1, 1'b0, "scan_to_manual");
    mode_a = 1;
    cyc(0, 8'h00, 4'd0, 1'b1, 1'b0, "reenter_scan0");
    cyc(0, 8'h00, 4'd0, 1'b1, 1'b0, "reenter_scan1");
    en_a = 0;
    cyc(0, 8'h00, 4'd0, 1'b0, 1'b0, "en_off");

    // Async reset mid-scan at ch 9
    en_a = 1; mode_a = 1; dwell_a = 8'd0;
    for (int i = 0; i < 10; i++) begin
      c = 4'(i);
      cyc(0, {4'h0, c}, c, 1'b1, 1'b0, "scan_pre_reset");
    end
    #2 rst_n = 1'b0;
    #1 check_now(0, 8'h00, 4'd0, 1'b0, 1'b0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c = 4'(i);
      cyc(0, {4'h0, c}, c, 1'b1, 1'b0, "scan_post_reset");
    end
    en_a = 0;
    cyc(0, 8'h02, 4'd2, 1'b0, 1'b0, "idle_end_a");

    // Non-power-of-2 instance: out-of-range select, then scan wrap at 9
    en_b = 1; mode_b = 0; sel_b = 4'd12;
    cyc(1, 8'h00, 4'd12, 1'b0, 1'b0, "b_manual_sel12");
    sel_b = 4'd9;
    cyc(1, 8'h19, 4'd9, 1'b1, 1'b0, "b_manual_sel9");
    mode_b = 1; dwell_b = 8'd0;
    for (int i = 0; i < 25; i++) begin
      c = 4'(i % 10);
      cyc(1, 8'(16 + (i % 10)), c, 1'b1, (i == 10) || (i == 20), "b_scan_dwell0");
    end
    en_b = 0;
    cyc(1, 8'h14, 4'd4, 1'b0, 1'b0, "b_idle_hold");

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
